// File: rtl/encoder4_2_rr.sv
// encoder4_2_rr: sticky 4-requester round-robin priority encoder with a
// valid/ready output stage.
//
// Requests on req are captured into a pending mask (pend) when e=1. A
// registered output stage presents one granted requester as a binary index
// (idx) plus a one-hot copy (grant). A handshake (valid & ready) retires the
// granted bit and advances the round-robin pointer past the granted index.
//
// Ports:
//   clk    in   1  rising-edge clock
//   reset  in   1  synchronous active-high reset
//   req    in   4  request lines, multi-hot allowed
//   e      in   1  capture enable for req
//   ready  in   1  consumer accepts the presented index this cycle
//   valid  out  1  idx/grant hold a granted request
//   idx    out  2  binary index of the granted requester
//   grant  out  4  one-hot copy of idx, zero when valid=0
//   pend   out  4  registered pending-request mask
module encoder4_2_rr #(
  parameter int delay = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       e,
  input  logic       ready,
  output logic       valid,
  output logic [1:0] idx,
  output logic [3:0] grant,
  output logic [3:0] pend
);

  // delay only applies to gate primitives; this design has none.
  if (delay < 0) begin : g_negative_delay
  end

  logic [3:0] pend_q, pend_d;
  logic       valid_q, valid_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] ptr_q, ptr_d;

  logic       hs;
  logic [3:0] hs_mask;
  logic [3:0] cand;
  logic       load;
  logic [1:0] sel;
  logic       found;

  always_comb begin
    hs      = valid_q & ready;
    hs_mask = hs ? grant_q : 4'b0000;
    // Selection uses only registered pend; fresh req never bypasses.
    cand    = pend_q & ~hs_mask;
    // Set wins over clear for a bit re-requested in its handshake cycle.
    pend_d  = cand | (e ? req : 4'b0000);
    load    = ~valid_q | hs;
    ptr_d   = hs ? idx_q + 2'd1 : ptr_q;
  end

  // Rotating first-one search starting at the post-handshake pointer, so
  // the just-served requester is scanned last.
  always_comb begin
    sel   = ptr_d;
    found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!found && cand[ptr_d + 2'(i)]) begin
        sel   = ptr_d + 2'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    grant_d = grant_q;
    if (load) begin
      if (found) begin
        valid_d = 1'b1;
        idx_d   = sel;
        grant_d = 4'b0001 << sel;
      end else begin
        // Nothing to grant: drop valid, keep the last index.
        valid_d = 1'b0;
        grant_d = 4'b0000;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q  <= 4'b0000;
      valid_q <= 1'b0;
      idx_q   <= 2'b00;
      grant_q <= 4'b0000;
      ptr_q   <= 2'b00;
    end else begin
      pend_q  <= pend_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign valid = valid_q;
  assign idx   = idx_q;
  assign grant = grant_q;
  assign pend  = pend_q;

endmodule

// File: tb/tb_encoder4_2_rr.sv
module tb_encoder4_2_rr;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic       e;
  logic       ready;
  logic       valid;
  logic [1:0] idx;
  logic [3:0] grant;
  logic [3:0] pend;

  int n_checks;
  int n_fail;

  encoder4_2_rr #(
    .delay(0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .req  (req),
    .e    (e),
    .ready(ready),
    .valid(valid),
    .idx  (idx),
    .grant(grant),
    .pend (pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One rising edge; return on the following falling edge for sampling/driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    e     = 1'b0;
    ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [1:0] i,
                           input logic [3:0] g, input logic [3:0] p);
    check_eq({tag, ".valid"}, 8'(valid), 8'(v));
    check_eq({tag, ".idx"},   8'(idx),   8'(i));
    check_eq({tag, ".grant"}, 8'(grant), 8'(g));
    check_eq({tag, ".pend"},  8'(pend),  8'(p));
  endtask

  logic [1:0] rr_seq [5];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rr_seq[0] = 2'd0;
    rr_seq[1] = 2'd1;
    rr_seq[2] = 2'd2;
    rr_seq[3] = 2'd3;
    rr_seq[4] = 2'd0;
    reset = 1'b1;
    req   = 4'b1111;
    e     = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    tick();

    // Reset state, with req/e asserted during reset (not captured).
    check_out("rst", 1'b0, 2'd0, 4'b0000, 4'b0000);
    check_eq("rst.ptr", 8'(dut.ptr_q), 8'd0);

    // Single one-cycle request on bit 2.
    do_reset();
    e = 1'b1; req = 4'b0100; ready = 1'b1;
    tick();
    check_out("single.cap", 1'b0, 2'd0, 4'b0000, 4'b0100);
    e = 1'b0; req = 4'b0000;
    tick();
    check_out("single.grant", 1'b1, 2'd2, 4'b0100, 4'b0100);
    tick();
    check_out("single.done", 1'b0, 2'd2, 4'b0000, 4'b0000);
    check_eq("single.ptr", 8'(dut.ptr_q), 8'd3);

    // All four held: strict rotation, one grant per cycle.
    do_reset();
    e = 1'b1; req = 4'b1111; ready = 1'b1;
    tick();
    check_out("all.cap", 1'b0, 2'd0, 4'b0000, 4'b1111);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq($sformatf("all.valid%0d", k), 8'(valid), 8'd1);
      check_eq($sformatf("all.idx%0d", k), 8'(idx), 8'(rr_seq[k]));
      check_eq($sformatf("all.grant%0d", k), 8'(grant), 8'(4'b0001 << rr_seq[k]));
    end

    // Stall: held output, then next requester after the handshake.
    do_reset();
    e = 1'b1; req = 4'b1010; ready = 1'b0;
    tick();
    e = 1'b0; req = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_out($sformatf("stall%0d", k), 1'b1, 2'd1, 4'b0010, 4'b1010);
    end
    ready = 1'b1;
    tick();
    check_out("stall.next", 1'b1, 2'd3, 4'b1000, 4'b1000);
    tick();
    check_out("stall.end", 1'b0, 2'd3, 4'b0000, 4'b0000);
    check_eq("stall.ptr", 8'(dut.ptr_q), 8'd0);

    // Capture gated by e.
    do_reset();
    e = 1'b0; req = 4'b0011; ready = 1'b0;
    tick();
    tick();
    check_out("gate.off", 1'b0, 2'd0, 4'b0000, 4'b0000);
    e = 1'b1;
    tick();
    check_out("gate.on", 1'b0, 2'd0, 4'b0000, 4'b0011);
    e = 1'b0; req = 4'b0000;
    tick();
    check_out("gate.grant", 1'b1, 2'd0, 4'b0001, 4'b0011);

    // Re-request in the handshake cycle: set wins, bit 0 served after bit 1.
    ready = 1'b1; e = 1'b1; req = 4'b0001;
    tick();
    check_out("rereq.hs", 1'b1, 2'd1, 4'b0010, 4'b0011);
    check_eq("rereq.ptr", 8'(dut.ptr_q), 8'd1);
    e = 1'b0; req = 4'b0000;
    tick();
    check_out("rereq.again", 1'b1, 2'd0, 4'b0001, 4'b0001);
    tick();
    check_out("rereq.end", 1'b0, 2'd0, 4'b0000, 4'b0000);

    // Reset during a stalled grant drops everything.
    do_reset();
    e = 1'b1; req = 4'b1100; ready = 1'b0;
    tick();
    e = 1'b0; req = 4'b0000;
    tick();
    check_out("rstgnt.pre", 1'b1, 2'd2, 4'b0100, 4'b1100);
    reset = 1'b1; e = 1'b1; req = 4'b0001;
    tick();
    check_out("rstgnt.post", 1'b0, 2'd0, 4'b0000, 4'b0000);
    check_eq("rstgnt.ptr", 8'(dut.ptr_q), 8'd0);
    reset = 1'b0;
    tick();
    check_out("rstgnt.resume", 1'b0, 2'd0, 4'b0000, 4'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
